alu_op_sequencer: RTL and testbench

Command front end for the bit-serial ALU. Accepts decoded ALU commands over a valid/ready handshake, buffers them, and drives the ALU's operation parameters with `op_valid` held stable until `op_done`. It serializes a 16-bit immediate onto `data_in2`, collects the serial result from `data_out` into a parallel word, and checks that every operation finishes on the expected cycle.

---
 rtl/alu_op_sequencer_if.sv | 64 ++++++
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the command handshake, the ALU parameter/stream bus and the
//   result/status outputs of alu_op_sequencer.
//   master : command source + ALU side (drives cmd_*, alu_op_done, alu_data_out)
//   slave  : the sequencer itself
`ifndef OP_BITS
`define OP_BITS 5
`endif

interface alu_op_sequencer_if #(
  parameter int LOG2_NR  = 3,
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int OP_BITS  = `OP_BITS
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_BITS-1:0]    cmd_op;
  logic [LOG2_NR-1:0]    cmd_reg1;
  logic [LOG2_NR-1:0]    cmd_reg2;
  logic                  cmd_pair;
  logic                  cmd_pair2;
  logic                  cmd_imm_en;
  logic [2*REG_BITS-1:0] cmd_imm;
  logic                  cmd_write;
  logic                  cmd_flags;

  logic                  alu_op_valid;
  logic [OP_BITS-1:0]    alu_operation;
  logic [LOG2_NR-1:0]    alu_reg1;
  logic [LOG2_NR-1:0]    alu_reg2;
  logic                  alu_pair_op;
  logic                  alu_pair_op2;
  logic                  alu_external_arg2;
  logic                  alu_update_reg1;
  logic                  alu_update_carry_flags;
  logic                  alu_update_other_flags;
  logic [NSHIFT-1:0]     alu_data_in2;
  logic                  alu_op_done;
  logic [NSHIFT-1:0]     alu_data_out;

  logic                  res_valid;
  logic [2*REG_BITS-1:0] res_data;
  logic                  busy;
  logic                  seq_error;

  modport master (
    output cmd_valid, cmd_op, cmd_reg1, cmd_reg2, cmd_pair, cmd_pair2,
           cmd_imm_en, cmd_imm, cmd_write, cmd_flags, alu_op_done, alu_data_out,
    input  cmd_ready, alu_op_valid, alu_operation, alu_reg1, alu_reg2,
           alu_pair_op, alu_pair_op2, alu_external_arg2, alu_update_reg1,
           alu_update_carry_flags, alu_update_other_flags, alu_data_in2,
           res_valid, res_data, busy, seq_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg1, cmd_reg2, cmd_pair, cmd_pair2,
           cmd_imm_en, cmd_imm, cmd_write, cmd_flags, alu_op_done, alu_data_out,
    output cmd_ready, alu_op_valid, alu_operation, alu_reg1, alu_reg2,
           alu_pair_op, alu_pair_op2, alu_external_arg2, alu_update_reg1,
           alu_update_carry_flags, alu_update_other_flags, alu_data_in2,
           res_valid, res_data, busy, seq_error
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command front end for the bit-serial ALU. Buffers decoded commands,
//   presents the head command to the ALU with op_valid held until op_done,
//   serializes the immediate onto alu_data_in2 (LSB first), deserializes
//   alu_data_out into res_data, and flags any op whose op_done does not land
//   on the expected cycle (sticky seq_error).
//
// Ports
//   clk   : the only clock
//   reset : synchronous, active-high
//   bus   : alu_op_sequencer_if.slave (command handshake, ALU bus, result/status)
//
// Build option
//   ALU_SEQ_QUEUE_EN defined   : 2-entry queue, zero-bubble back-to-back ops.
//   ALU_SEQ_QUEUE_EN undefined : single holding register, cmd_ready = !busy,
//                                so consecutive ops are separated by an idle cycle.
`ifndef OP_BITS
`define OP_BITS 5
`endif

module alu_op_sequencer #(
  parameter int LOG2_NR  = 3,
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int OP_BITS  = `OP_BITS
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam int W     = 2*REG_BITS;
  localparam int LEN_W = $clog2(W/NSHIFT);
  // Down-counter reload values: terminal count 0 is the cycle op_done is due.
  localparam logic [LEN_W-1:0] LEN_SINGLE = LEN_W'(REG_BITS/NSHIFT - 1);
  localparam logic [LEN_W-1:0] LEN_PAIR   = LEN_W'(W/NSHIFT - 1);

  typedef struct packed {
    logic [OP_BITS-1:0] op;
    logic [LOG2_NR-1:0] reg1;
    logic [LOG2_NR-1:0] reg2;
    logic               pair;
    logic               pair2;
    logic               imm_en;
    logic               write;
    logic               flags;
    logic [W-1:0]       imm;
  } cmd_t;

  cmd_t             in_cmd;
  cmd_t             head;
  cmd_t             slot0_q, slot0_d;
  logic [1:0]       count_q, count_d;
  logic [W-1:0]     imm_sh_q, imm_sh_d;
  logic [W-1:0]     res_sh_q, res_sh_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic [W-1:0]     res_next, res_aligned;
  logic [LEN_W-1:0] len_q, len_d;
  logic             res_valid_q;
  logic             seq_error_q, seq_error_d;
  logic             active, push, pop, start, len_tc;

`ifdef ALU_SEQ_QUEUE_EN
  cmd_t             slot1_q, slot1_d;
`endif

  always_comb begin
    in_cmd.op     = bus.cmd_op;
    in_cmd.reg1   = bus.cmd_reg1;
    in_cmd.reg2   = bus.cmd_reg2;
    in_cmd.pair   = bus.cmd_pair;
    in_cmd.pair2  = bus.cmd_pair2;
    in_cmd.imm_en = bus.cmd_imm_en;
    in_cmd.write  = bus.cmd_write;
    in_cmd.flags  = bus.cmd_flags;
    in_cmd.imm    = bus.cmd_imm;
  end

  assign head   = slot0_q;
  assign active = (count_q != 2'd0);
  assign pop    = active && bus.alu_op_done;

  // Ready depends only on registered occupancy, never on alu_op_done.
`ifdef ALU_SEQ_QUEUE_EN
  assign bus.cmd_ready = (count_q != 2'd2);
`else
  assign bus.cmd_ready = (count_q == 2'd0);
`endif
  assign push = bus.cmd_valid && bus.cmd_ready;

  // Queue occupancy; slot0 is always the head.
  always_comb begin
    slot0_d = slot0_q;
    count_d = count_q;
`ifdef ALU_SEQ_QUEUE_EN
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = in_cmd;
        else                 slot1_d = in_cmd;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry (full refuses pushes).
        slot0_d = in_cmd;
      end
      default: ;
    endcase
`else
    if (pop) begin
      count_d = 2'd0;
    end else if (push) begin
      slot0_d = in_cmd;
      count_d = 2'd1;
    end
`endif
  end

  // A new op begins on the edge where a (new) head appears.
  assign start = (count_d != 2'd0) && ((count_q == 2'd0) || pop);

  assign len_tc      = (len_q == '0);
  assign res_next    = {bus.alu_data_out, res_sh_q[W-1:NSHIFT]};
  // A single op shifts in only REG_BITS bits, which end up in the top half.
  assign res_aligned = head.pair ? res_next : {{REG_BITS{1'b0}}, res_next[W-1:REG_BITS]};

  always_comb begin
    imm_sh_d    = imm_sh_q;
    res_sh_d    = res_sh_q;
    len_d       = len_q;
    res_data_d  = res_data_q;
    seq_error_d = seq_error_q;
    // op_done must coincide exactly with terminal count.
    if (active && (bus.alu_op_done != len_tc)) seq_error_d = 1'b1;
    if (pop) res_data_d = res_aligned;
    if (start) begin
      imm_sh_d = slot0_d.imm;
      res_sh_d = '0;
      len_d    = slot0_d.pair ? LEN_PAIR : LEN_SINGLE;
    end else if (active) begin
      imm_sh_d = imm_sh_q >> NSHIFT;
      res_sh_d = res_next;
      if (!len_tc) len_d = len_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q     <= '0;
`ifdef ALU_SEQ_QUEUE_EN
      slot1_q     <= '0;
`endif
      count_q     <= 2'd0;
      imm_sh_q    <= '0;
      res_sh_q    <= '0;
      len_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      slot0_q     <= slot0_d;
`ifdef ALU_SEQ_QUEUE_EN
      slot1_q     <= slot1_d;
`endif
      count_q     <= count_d;
      imm_sh_q    <= imm_sh_d;
      res_sh_q    <= res_sh_d;
      len_q       <= len_d;
      res_data_q  <= res_data_d;
      res_valid_q <= pop;
      seq_error_q <= seq_error_d;
    end
  end

  assign bus.alu_op_valid           = active;
  assign bus.alu_operation          = active ? head.op    : '0;
  assign bus.alu_reg1               = active ? head.reg1  : '0;
  assign bus.alu_reg2               = active ? head.reg2  : '0;
  assign bus.alu_pair_op            = active && head.pair;
  assign bus.alu_pair_op2           = active && head.pair2;
  assign bus.alu_external_arg2      = active && head.imm_en;
  assign bus.alu_update_reg1        = active && head.write;
  assign bus.alu_update_carry_flags = active && head.flags;
  assign bus.alu_update_other_flags = active && head.flags;
  assign bus.alu_data_in2           = (active && head.imm_en) ? imm_sh_q[NSHIFT-1:0] : '0;
  assign bus.res_valid              = res_valid_q;
  assign bus.res_data               = res_data_q;
  assign bus.busy                   = active;
  assign bus.seq_error              = seq_error_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`ifndef OP_BITS
`define OP_BITS 5
`endif

module tb_alu_op_sequencer;
  localparam int OPB = `OP_BITS;

  logic clk = 1'b0;
  logic reset;

  alu_op_sequencer_if #(.LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .OP_BITS(OPB)) bus ();

  alu_op_sequencer #(.LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .OP_BITS(OPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPB-1:0] op;
    logic [2:0]     r1;
    logic [2:0]     r2;
    logic           pair;
    logic           pair2;
    logic           imm_en;
    logic           wr;
    logic           fl;
    logic [15:0]    imm;
    logic [15:0]    alu_word;
    int             exp_len;
    logic [15:0]    exp_res;
    logic [15:0]    exp_din;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // ALU model: counts cycles of the current op, raises op_done on cycle
  // done_at (or the natural length), streams alu_word, or echoes arg2 for
  // immediate ops.
  int          done_at  = 0;
  logic [15:0] alu_word = 16'h0;
  int          k = 0;
  bit          done_prev = 1'b0;

  always @(posedge clk) begin
    int len;
    int tgt;
    #1;
    if (reset || !bus.alu_op_valid) k = 0;
    else if (done_prev)             k = 1;
    else                            k = k + 1;
    len = bus.alu_pair_op ? 8 : 4;
    tgt = (done_at != 0) ? done_at : len;
    bus.alu_op_done = (k != 0) && (k == tgt);
    if (k != 0 && k <= 8)
      bus.alu_data_out = bus.alu_external_arg2 ? bus.alu_data_in2 : alu_word[2*(k-1) +: 2];
    else
      bus.alu_data_out = 2'b00;
    done_prev = bus.alu_op_done;
  end

  int cyc = 0;
  bit ov_log [0:4095];
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (cyc < 4096) ov_log[cyc] = bus.alu_op_valid;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    done_at = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input vec_t v, output bit ok);
    int n;
    n = 0;
    bus.cmd_op     = v.op;
    bus.cmd_reg1   = v.r1;
    bus.cmd_reg2   = v.r2;
    bus.cmd_pair   = v.pair;
    bus.cmd_pair2  = v.pair2;
    bus.cmd_imm_en = v.imm_en;
    bus.cmd_write  = v.wr;
    bus.cmd_flags  = v.fl;
    bus.cmd_imm    = v.imm;
    bus.cmd_valid  = 1'b1;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = bus.cmd_ready;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit          ok;
    int          n;
    logic [15:0] din_seq;
    alu_word = v.alu_word;
    push(v, ok);
    chk($sformatf("v%0d_accept", idx), 32'(ok), 32'd1);
    chk($sformatf("v%0d_params", idx),
        32'({bus.alu_op_valid, bus.alu_operation, bus.alu_reg1, bus.alu_reg2, bus.alu_pair_op,
             bus.alu_pair_op2, bus.alu_external_arg2, bus.alu_update_reg1,
             bus.alu_update_carry_flags, bus.alu_update_other_flags}),
        32'({1'b1, v.op, v.r1, v.r2, v.pair, v.pair2, v.imm_en, v.wr, v.fl, v.fl}));
    n = 0;
    din_seq = 16'h0;
    while (bus.alu_op_valid && n < 20) begin
      if (n < 8) din_seq[2*n +: 2] = bus.alu_data_in2;
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_len", idx), 32'(n), 32'(v.exp_len));
    chk($sformatf("v%0d_res_valid", idx), 32'(bus.res_valid), 32'd1);
    chk($sformatf("v%0d_res_data", idx), 32'(bus.res_data), 32'(v.exp_res));
    chk($sformatf("v%0d_din_seq", idx), 32'(din_seq), 32'(v.exp_din));
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), 32'({bus.res_valid, bus.res_data}), 32'({1'b0, v.exp_res}));
  endtask

  initial begin
    vec_t        vecs [4];
    bit          ok;
    bit          seen;
    int          c0;
    logic [19:0] pat;
    logic [19:0] exp_pat;

    vecs[0] = '{op: OPB'(1),  r1: 3'd1, r2: 3'd2, pair: 1'b0, pair2: 1'b0, imm_en: 1'b0, wr: 1'b1, fl: 1'b1,
                imm: 16'h0000, alu_word: 16'h12B7, exp_len: 4, exp_res: 16'h00B7, exp_din: 16'h0000};
    vecs[1] = '{op: OPB'(2),  r1: 3'd3, r2: 3'd0, pair: 1'b1, pair2: 1'b0, imm_en: 1'b1, wr: 1'b1, fl: 1'b0,
                imm: 16'hA5C3, alu_word: 16'h0000, exp_len: 8, exp_res: 16'hA5C3, exp_din: 16'hA5C3};
    vecs[2] = '{op: OPB'(10), r1: 3'd7, r2: 3'd6, pair: 1'b1, pair2: 1'b1, imm_en: 1'b0, wr: 1'b0, fl: 1'b1,
                imm: 16'hFFFF, alu_word: 16'hBEEF, exp_len: 8, exp_res: 16'hBEEF, exp_din: 16'h0000};
    vecs[3] = '{op: OPB'(31), r1: 3'd4, r2: 3'd5, pair: 1'b0, pair2: 1'b1, imm_en: 1'b1, wr: 1'b0, fl: 1'b0,
                imm: 16'h775A, alu_word: 16'hFFFF, exp_len: 4, exp_res: 16'h005A, exp_din: 16'h005A};

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_reg1   = '0;
    bus.cmd_reg2   = '0;
    bus.cmd_pair   = 1'b0;
    bus.cmd_pair2  = 1'b0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_flags  = 1'b0;
    bus.cmd_imm    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_op_valid",  32'(bus.alu_op_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data), 32'd0);
    chk("rst_seq_error", 32'(bus.seq_error), 32'd0);
    chk("rst_params",    32'({bus.alu_operation, bus.alu_reg1, bus.alu_reg2, bus.alu_data_in2,
                              bus.alu_pair_op, bus.alu_update_carry_flags}), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    chk("vec_seq_error", 32'(bus.seq_error), 32'd0);

    // Two pair ops offered in consecutive cycles.
    alu_word = vecs[2].alu_word;
    push(vecs[2], ok);
    c0 = cyc;
`ifdef ALU_SEQ_QUEUE_EN
    push(vecs[1], ok);
    chk("b2b_second_accept", 32'(ok), 32'd1);
    bus.cmd_op    = vecs[0].op;
    bus.cmd_pair  = 1'b0;
    bus.cmd_valid = 1'b1;
    chk("b2b_full_refuse", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    exp_pat = 20'h0FFFF;
`else
    chk("b2b_busy_ready_low", 32'(bus.cmd_ready), 32'd0);
    push(vecs[1], ok);
    chk("b2b_second_accept", 32'(ok), 32'd1);
    exp_pat = 20'h1FEFF;
`endif
    repeat (25) @(negedge clk);
    for (int j = 0; j < 20; j++) pat[j] = ov_log[c0 + j];
    chk("b2b_op_valid_pattern", 32'(pat), 32'(exp_pat));
    chk("b2b_last_result", 32'(bus.res_data), 32'h0000A5C3);
    chk("b2b_idle", 32'({bus.busy, bus.cmd_ready}), 32'b01);

    // op_done later than the terminal count.
    do_reset();
    done_at  = 6;
    alu_word = 16'h0033;
    push(vecs[0], ok);
    repeat (3) @(negedge clk);
    chk("late_no_err_yet", 32'(bus.seq_error), 32'd0);
    @(negedge clk);
    chk("late_err", 32'({bus.seq_error, bus.alu_op_valid}), 32'b11);
    repeat (2) @(negedge clk);
    chk("late_pop_on_done", 32'({bus.alu_op_valid, bus.res_valid}), 32'b01);
    done_at = 0;

    // op_done earlier than the terminal count.
    do_reset();
    chk("err_cleared_by_reset", 32'(bus.seq_error), 32'd0);
    done_at  = 3;
    alu_word = 16'h0055;
    push(vecs[0], ok);
    repeat (2) @(negedge clk);
    chk("early_no_err_yet", 32'(bus.seq_error), 32'd0);
    @(negedge clk);
    chk("early_err_popped", 32'({bus.seq_error, bus.alu_op_valid, bus.busy, bus.res_valid}), 32'b1001);
    done_at = 0;
    run_vec(vecs[3], 4);
    chk("err_sticky", 32'(bus.seq_error), 32'd1);

    // Reset in cycle 2 of a pair op.
    do_reset();
    alu_word = 16'hBEEF;
    push(vecs[2], ok);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_state", 32'({bus.alu_op_valid, bus.busy, bus.cmd_ready, bus.seq_error}), 32'b0010);
    chk("midrst_res_data", 32'(bus.res_data), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("midrst_no_res_valid", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
